div_issue_unit: RTL and testbench

// - Upstream stage of int_divider. Accepts DIV/REM requests from execute, resolves RISC-V special cases locally, forwards the rest to int_divider.
// - Holds one request in flight, carries its destination tag and returns one result per request, in order.
// - Special cases handled locally: divide-by-zero, and signed overflow MIN/-1.

---
 rtl/div_issue_unit_pkg.sv | 30 +++
 rtl/div_issue_unit_special_case.sv | 37 +++
 rtl/div_issue_unit.sv | 127 ++++++++++++
 tb/tb_div_issue_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_unit_pkg.sv
// CPU_pkg: shared divider opcodes, the issue-unit FSM state type and a
// helper to classify signed divide operations. Imported by the divider
// issue stage and its special-case decoder.
package CPU_pkg;

  // Opcode encoding: bit 0 = signed, bit 1 = remainder.
  typedef enum logic [1:0] {
    UDIV = 2'd0,
    SDIV = 2'd1,
    UREM = 2'd2,
    SREM = 2'd3
  } div_op_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    DRAIN
  } div_issue_state_t;

  function automatic logic is_signed_div_op(input logic [1:0] op);
    return (op == SDIV) || (op == SREM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return (op == UREM) || (op == SREM);
  endfunction

endpackage

// File: rtl/div_issue_unit_special_case.sv
// div_special_case: combinational detector for the RISC-V divide corner
// cases that the issue unit answers locally instead of using the divider.
//   op        in  2  UDIV/SDIV/UREM/SREM
//   a         in  N  dividend
//   b         in  N  divisor
//   bypass    out 1  request is answered locally
//   bypass_y  out N  local answer, valid when bypass is high
module div_special_case
  import CPU_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         bypass,
  output logic [N-1:0] bypass_y
);

  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  // NOTE: every output gets a default before any branch, so no latch is inferred.
  always_comb begin
    bypass   = 1'b0;
    bypass_y = '0;
    if (b == '0) begin
      // Divide by zero: quotient all-ones, remainder is the dividend.
      bypass   = 1'b1;
      bypass_y = is_rem_op(op) ? a : '1;
    end else if (is_signed_div_op(op) && (a == MIN_VAL) && (b == '1)) begin
      // Signed overflow MIN / -1: quotient MIN, remainder zero.
      bypass   = 1'b1;
      bypass_y = is_rem_op(op) ? '0 : a;
    end
  end

endmodule

// File: rtl/div_issue_unit.sv
// div_issue_unit: upstream stage of int_divider. Accepts one DIV/REM
// request at a time, answers divide-by-zero and MIN/-1 locally, forwards
// everything else to the external int_divider and returns one tagged
// result per request, in order.
//   clk, reset                      clock, async active-high reset
//   flush                           kill in-flight request (synchronous)
//   valid_in/ready_out/op/a/b/tag_in request channel
//   valid_out/ready_in/y/tag_out    result channel
//   div_valid/div_ready/div_op/div_a/div_b   request to int_divider
//   div_res_valid/div_res_ready/div_y        result from int_divider
module div_issue_unit
  import CPU_pkg::*;
#(
  parameter int N     = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [1:0]       op,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [N-1:0]     y,
  output logic [TAG_W-1:0] tag_out,
  output logic             div_valid,
  input  logic             div_ready,
  output logic [1:0]       div_op,
  output logic [N-1:0]     div_a,
  output logic [N-1:0]     div_b,
  input  logic             div_res_valid,
  output logic             div_res_ready,
  input  logic [N-1:0]     div_y
);

  div_issue_state_t state_q, state_d;
  logic [1:0]       op_q;
  logic [N-1:0]     a_q, b_q, y_q;
  logic [TAG_W-1:0] tag_q;

  logic             bypass;
  logic [N-1:0]     bypass_y;
  logic             accept;
  logic             div_capture;

  div_special_case #(.N(N)) u_special (
    .op       (op),
    .a        (a),
    .b        (b),
    .bypass   (bypass),
    .bypass_y (bypass_y)
  );

  // A flush in the same cycle as an offered request wins: nothing is taken.
  assign accept      = (state_q == IDLE) && valid_in && !flush;
  assign div_capture = (state_q == WAIT) && div_res_valid && !flush;

  always_comb begin
    state_d       = state_q;
    ready_out     = 1'b0;
    valid_out     = 1'b0;
    div_valid     = 1'b0;
    div_res_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        if (accept) state_d = bypass ? DONE : ISSUE;
      end
      ISSUE: begin
        div_valid     = 1'b1;
        div_res_ready = 1'b1; // int_divider only raises ready_out while its ready_in is high
        if (flush)          state_d = div_ready ? DRAIN : IDLE;
        else if (div_ready) state_d = WAIT;
      end
      WAIT: begin
        div_res_ready = 1'b1;
        // If the divider result lands in the flush cycle, its handshake
        // completes now, so there is nothing left to drain.
        if (flush)              state_d = div_res_valid ? IDLE : DRAIN;
        else if (div_res_valid) state_d = DONE;
      end
      DONE: begin
        valid_out = 1'b1;
        if (flush || ready_in) state_d = IDLE;
      end
      DRAIN: begin
        div_res_ready = 1'b1;
        if (div_res_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op;
        a_q   <= a;
        b_q   <= b;
        tag_q <= tag_in;
        if (bypass) y_q <= bypass_y;
      end
      if (div_capture) y_q <= div_y;
    end
  end

  assign div_op  = op_q;
  assign div_a   = a_q;
  assign div_b   = b_q;
  assign y       = y_q;
  assign tag_out = tag_q;

endmodule

// File: tb/tb_div_issue_unit.sv
// Testbench for div_issue_unit: behavioural int_divider model, scoreboard
// queue filled by the stimulus and emptied by an independent monitor.
module tb_div_issue_unit;
  import CPU_pkg::*;

  localparam int N     = 32;
  localparam int TAG_W = 5;
  localparam logic [N-1:0] MIN_VAL = 32'h8000_0000;

  logic             clk, reset, flush;
  logic             valid_in, ready_out;
  logic [1:0]       op;
  logic [N-1:0]     a, b;
  logic [TAG_W-1:0] tag_in;
  logic             valid_out, ready_in;
  logic [N-1:0]     y;
  logic [TAG_W-1:0] tag_out;
  logic             div_valid, div_ready;
  logic [1:0]       div_op;
  logic [N-1:0]     div_a, div_b;
  logic             div_res_valid, div_res_ready;
  logic [N-1:0]     div_y;

  div_issue_unit #(.N(N), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .ready_out(ready_out), .op(op), .a(a), .b(b), .tag_in(tag_in),
    .valid_out(valid_out), .ready_in(ready_in), .y(y), .tag_out(tag_out),
    .div_valid(div_valid), .div_ready(div_ready), .div_op(div_op), .div_a(div_a), .div_b(div_b),
    .div_res_valid(div_res_valid), .div_res_ready(div_res_ready), .div_y(div_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: RISC-V divide semantics in plain arithmetic.
  function automatic logic [N-1:0] ref_result(input logic [1:0] rop, input logic [N-1:0] ra,
                                              input logic [N-1:0] rb);
    logic signed [N-1:0] sa, sb;
    sa = ra;
    sb = rb;
    case (rop)
      UDIV:    return (rb == 0) ? '1 : ra / rb;
      UREM:    return (rb == 0) ? ra : ra % rb;
      SDIV: begin
        if (rb == 0) return '1;
        if (ra == MIN_VAL && rb == '1) return MIN_VAL;
        return sa / sb;
      end
      default: begin
        if (rb == 0) return ra;
        if (ra == MIN_VAL && rb == '1) return '0;
        return sa % sb;
      end
    endcase
  endfunction

  function automatic logic is_special(input logic [1:0] rop, input logic [N-1:0] ra,
                                      input logic [N-1:0] rb);
    return (rb == 0) || (rop[0] && ra == MIN_VAL && rb == '1);
  endfunction

  // ---------------- behavioural int_divider ----------------
  logic         stall;
  int           force_lat;
  logic         m_busy, m_res_valid, m_have_last;
  int           m_cnt;
  logic [N-1:0] m_y, m_last_a, m_last_b;
  logic [1:0]   m_last_op;

  assign div_ready     = !m_busy && !m_res_valid && div_res_ready && !stall;
  assign div_res_valid = m_res_valid;
  assign div_y         = m_y;

  // Special operands must never arrive here; a marker value exposes it.
  function automatic logic [N-1:0] model_div(input logic [1:0] mop, input logic [N-1:0] ma,
                                             input logic [N-1:0] mb);
    if (is_special(mop, ma, mb)) return 32'hDEAD_BEEF;
    return ref_result(mop, ma, mb);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy      <= 1'b0;
      m_res_valid <= 1'b0;
      m_have_last <= 1'b0;
      m_cnt       <= 0;
      m_y         <= '0;
      m_last_a    <= '0;
      m_last_b    <= '0;
      m_last_op   <= '0;
    end else begin
      if (m_res_valid && div_res_ready) m_res_valid <= 1'b0;
      if (div_valid && div_ready) begin
        m_busy      <= 1'b1;
        m_y         <= model_div(div_op, div_a, div_b);
        // Same operands, same signedness, other half of DIV/REM: cached.
        if (m_have_last && div_a == m_last_a && div_b == m_last_b &&
            div_op[0] == m_last_op[0] && div_op[1] != m_last_op[1])
          m_cnt <= 1;
        else
          m_cnt <= (force_lat > 0) ? force_lat : int'($urandom_range(2, 6));
        m_have_last <= 1'b1;
        m_last_a    <= div_a;
        m_last_b    <= div_b;
        m_last_op   <= div_op;
      end else if (m_busy) begin
        if (m_cnt <= 1) begin
          m_busy      <= 1'b0;
          m_res_valid <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    logic [N-1:0]     y;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t         exp_q[$];
  int           results  = 0;
  int           div_hs   = 0;
  int           exp_fwd  = 0;
  logic         hold_low = 1'b0;
  logic         held     = 1'b0;
  logic [N-1:0]     prev_y;
  logic [TAG_W-1:0] prev_tag;

  always @(posedge clk) begin
    #1;
    ready_in = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (div_valid && div_ready) div_hs++;
      if (valid_out) begin
        check("ready_out_in_done", {31'b0, ready_out}, 32'd0);
        if (held) begin
          check("y_stable", y, prev_y);
          check("tag_stable", {27'b0, tag_out}, {27'b0, prev_tag});
        end
        if (ready_in) begin
          held = 1'b0;
          results++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%h expected=none", y);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result_y", y, e.y);
            check("result_tag", {27'b0, tag_out}, {27'b0, e.tag});
          end
        end else begin
          held     = 1'b1;
          prev_y   = y;
          prev_tag = tag_out;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [1:0] sop, input logic [N-1:0] sa, input logic [N-1:0] sb,
                      input logic [TAG_W-1:0] stag, input logic push);
    int guard;
    exp_t e;
    @(negedge clk);
    valid_in = 1'b1;
    op       = sop;
    a        = sa;
    b        = sb;
    tag_in   = stag;
    guard    = 0;
    while (!ready_out && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=ready_out_low expected=accept");
    end
    if (push) begin
      e.y   = ref_result(sop, sa, sb);
      e.tag = stag;
      exp_q.push_back(e);
    end
    if (!is_special(sop, sa, sb)) exp_fwd++;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !ready_out) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending expected=0", exp_q.size());
    end
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return MIN_VAL;
      3:       return N'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int r0, h0;
    reset     = 1'b1;
    flush     = 1'b0;
    valid_in  = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    tag_in    = '0;
    ready_in  = 1'b0;
    stall     = 1'b0;
    force_lat = 0;
    #12;
    check("rst_valid_out", {31'b0, valid_out}, 32'd0);
    check("rst_div_valid", {31'b0, div_valid}, 32'd0);
    check("rst_div_res_ready", {31'b0, div_res_ready}, 32'd0);
    check("rst_ready_out", {31'b0, ready_out}, 32'd1);
    check("rst_y", y, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Forwarded UDIV: one result, tag preserved.
    r0 = results;
    send(UDIV, 32'd100, 32'd7, 5'd17, 1'b1);
    drain();
    check("udiv_one_pulse", results - r0, 32'd1);

    // Divide by zero: bypassed, result visible the cycle after accept.
    h0 = div_hs;
    send(SDIV, -32'sd7, 32'd0, 5'd3, 1'b1);
    check("dz_next_cycle_valid", {31'b0, valid_out}, 32'd1);
    check("dz_next_cycle_y", y, 32'hFFFF_FFFF);
    send(SREM, -32'sd7, 32'd0, 5'd4, 1'b1);
    drain();
    // Signed overflow MIN / -1.
    send(SDIV, MIN_VAL, '1, 5'd5, 1'b1);
    send(SREM, MIN_VAL, '1, 5'd6, 1'b1);
    drain();
    check("bypass_no_issue", div_hs - h0, 32'd0);

    // Back-to-back SDIV/SREM on the same operands.
    send(SDIV, -32'sd20, 32'd3, 5'd7, 1'b1);
    send(SREM, -32'sd20, 32'd3, 5'd8, 1'b1);
    drain();

    // Result held in DONE while the consumer stalls.
    hold_low = 1'b1;
    @(negedge clk);
    send(UDIV, 32'd5, 32'd0, 5'd9, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid_out", {31'b0, valid_out}, 32'd1);
      check("hold_y", y, 32'hFFFF_FFFF);
      check("hold_ready_out", {31'b0, ready_out}, 32'd0);
      @(negedge clk);
    end
    hold_low = 1'b0;
    drain();

    // Flush in WAIT: divider result is drained and dropped.
    force_lat = 6;
    send(UDIV, 32'd50, 32'd5, 5'd10, 1'b0);
    check("flw_issue", {31'b0, div_valid}, 32'd1);
    @(negedge clk);
    check("flw_wait", {31'b0, div_valid}, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flw_drain_ready_out", {31'b0, ready_out}, 32'd0);
    repeat (10) @(negedge clk);
    check("flw_back_idle", {31'b0, ready_out}, 32'd1);
    force_lat = 0;
    send(UREM, 32'd9, 32'd4, 5'd11, 1'b1);
    drain();

    // Flush in ISSUE without divider handshake: straight back to IDLE.
    stall = 1'b1;
    send(UDIV, 32'd77, 32'd3, 5'd12, 1'b0);
    exp_fwd--;
    @(negedge clk);
    check("fli_issue", {31'b0, div_valid}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fli_idle", {31'b0, ready_out}, 32'd1);
    check("fli_no_div_valid", {31'b0, div_valid}, 32'd0);
    stall = 1'b0;

    // Asynchronous reset while in ISSUE.
    stall = 1'b1;
    send(SDIV, 32'd100, 32'd9, 5'd13, 1'b0);
    exp_fwd--;
    check("rsti_issue", {31'b0, div_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rsti_div_valid", {31'b0, div_valid}, 32'd0);
    check("rsti_div_a", div_a, 32'd0);
    check("rsti_div_b", div_b, 32'd0);
    check("rsti_div_op", {30'b0, div_op}, 32'd0);
    check("rsti_y", y, 32'd0);
    check("rsti_tag", {27'b0, tag_out}, 32'd0);
    check("rsti_valid_out", {31'b0, valid_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;

    // Randomised traffic.
    for (int i = 0; i < 150; i++)
      send(2'($urandom_range(0, 3)), pick(), pick(), 5'($urandom), 1'b1);
    drain();
    check("fwd_count", div_hs, exp_fwd);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
